// File: rtl/y86_decode_stage_if.sv
// y86_decode_stage_if
//   Bundles every non-clock/reset signal of the Y86-64 decode stage.
//   slave  : the decode stage itself (consumes fetch/forwarding, drives E outputs)
//   master : whoever surrounds it (fetch, hazard unit, later stages, or a bench)
// Signal groups:
//   f_bundle                 145-bit fetch output {err,icode,ifun,rA,rB,valC,valP}
//   D_stall/D_bubble/E_bubble pipeline control from the hazard unit
//   e_*/M_*/m_*/W_*          forwarding sources and register write-back
//   d_srcA/d_srcB            combinational decoded sources (to hazard unit)
//   E_*                      E pipeline register contents (to execute)
interface y86_decode_stage_if #(
  parameter int DATA_W = 64
);
  logic [2*DATA_W+16:0] f_bundle;
  logic                 D_stall;
  logic                 D_bubble;
  logic                 E_bubble;

  logic [3:0]           e_dstE;
  logic [DATA_W-1:0]    e_valE;
  logic [3:0]           M_dstM;
  logic [DATA_W-1:0]    m_valM;
  logic [3:0]           M_dstE;
  logic [DATA_W-1:0]    M_valE;
  logic [3:0]           W_dstM;
  logic [DATA_W-1:0]    W_valM;
  logic [3:0]           W_dstE;
  logic [DATA_W-1:0]    W_valE;

  logic [3:0]           d_srcA;
  logic [3:0]           d_srcB;

  logic                 E_err;
  logic [3:0]           E_icode;
  logic [3:0]           E_ifun;
  logic [DATA_W-1:0]    E_valC;
  logic [DATA_W-1:0]    E_valA;
  logic [DATA_W-1:0]    E_valB;
  logic [3:0]           E_dstE;
  logic [3:0]           E_dstM;
  logic [3:0]           E_srcA;
  logic [3:0]           E_srcB;

  modport slave (
    input  f_bundle, D_stall, D_bubble, E_bubble,
    input  e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    input  W_dstM, W_valM, W_dstE, W_valE,
    output d_srcA, d_srcB,
    output E_err, E_icode, E_ifun, E_valC, E_valA, E_valB,
    output E_dstE, E_dstM, E_srcA, E_srcB
  );

  modport master (
    output f_bundle, D_stall, D_bubble, E_bubble,
    output e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
    output W_dstM, W_valM, W_dstE, W_valE,
    input  d_srcA, d_srcB,
    input  E_err, E_icode, E_ifun, E_valC, E_valA, E_valB,
    input  E_dstE, E_dstM, E_srcA, E_srcB
  );
endinterface

// File: rtl/y86_decode_stage.sv
// y86_decode_stage
//   Decode stage of the five-stage Y86-64 pipeline. Holds the D pipeline
//   register, decodes register sources/destinations, reads the 15-entry
//   register file with E/M/W forwarding, and loads the E pipeline register.
//   The register file lives here and is written from the W stage.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (both pipeline registers -> nop,
//        register file -> 0)
//   bus  y86_decode_stage_if.slave, see the interface header for signals
module y86_decode_stage #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input logic                   clk,
  input logic                   rst,
  y86_decode_stage_if.slave     bus
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Field order matches the fetch bundle bit layout exactly.
  typedef struct packed {
    logic              err;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [DATA_W-1:0] valc;
    logic [DATA_W-1:0] valp;
  } d_reg_t;

  typedef struct packed {
    logic              err;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] valc;
    logic [DATA_W-1:0] vala;
    logic [DATA_W-1:0] valb;
    logic [3:0]        dste;
    logic [3:0]        dstm;
    logic [3:0]        srca;
    logic [3:0]        srcb;
  } e_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    err: 1'b0, icode: I_NOP, ifun: 4'h0, ra: RNONE, rb: RNONE,
    valc: '0, valp: '0
  };

  localparam e_reg_t E_BUBBLE = '{
    err: 1'b0, icode: I_NOP, ifun: 4'h0, valc: '0, vala: '0, valb: '0,
    dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
  };

  d_reg_t            d_q;
  e_reg_t            e_q;
  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        d_srca;
  logic [3:0]        d_srcb;
  logic [3:0]        d_dste;
  logic [3:0]        d_dstm;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] d_vala;
  logic [DATA_W-1:0] d_valb;

  // D pipeline register: stall has priority over bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= D_BUBBLE;
    end else if (bus.D_stall) begin
      d_q <= d_q;
    end else if (bus.D_bubble) begin
      d_q <= D_BUBBLE;
    end else begin
      d_q <= d_reg_t'(bus.f_bundle);
    end
  end

  // Register source/destination decode from the D register icode.
  always_comb begin
    d_srca = RNONE;
    d_srcb = RNONE;
    d_dste = RNONE;
    d_dstm = RNONE;

    case (d_q.icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srca = d_q.ra;
      I_RET, I_POPQ:                      d_srca = RSP;
      default:                            d_srca = RNONE;
    endcase

    case (d_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcb = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcb = RSP;
      default:                            d_srcb = RNONE;
    endcase

    case (d_q.icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dste = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dste = RSP;
      default:                            d_dste = RNONE;
    endcase

    case (d_q.icode)
      I_MRMOVQ, I_POPQ:                   d_dstm = d_q.ra;
      default:                            d_dstm = RNONE;
    endcase
  end

  // Register file read. Index RNONE matches no entry and reads as zero.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (d_srca == 4'(i)) rf_a = regs[i];
      if (d_srcb == 4'(i)) rf_b = regs[i];
    end
  end

  // Forwarding: the youngest producer wins (execute, then memory, then
  // write-back). The W entries also cover a register written this same
  // cycle, since the file read above still shows the old value. valM
  // beats valE at each stage so a popq into %rsp sees the loaded value.
  always_comb begin
    if (d_q.icode == I_JXX || d_q.icode == I_CALL) begin
      d_vala = d_q.valp;
    end else if (d_srca == RNONE) begin
      d_vala = '0;
    end else if (d_srca == bus.e_dstE) begin
      d_vala = bus.e_valE;
    end else if (d_srca == bus.M_dstM) begin
      d_vala = bus.m_valM;
    end else if (d_srca == bus.M_dstE) begin
      d_vala = bus.M_valE;
    end else if (d_srca == bus.W_dstM) begin
      d_vala = bus.W_valM;
    end else if (d_srca == bus.W_dstE) begin
      d_vala = bus.W_valE;
    end else begin
      d_vala = rf_a;
    end
  end

  always_comb begin
    if (d_srcb == RNONE) begin
      d_valb = '0;
    end else if (d_srcb == bus.e_dstE) begin
      d_valb = bus.e_valE;
    end else if (d_srcb == bus.M_dstM) begin
      d_valb = bus.m_valM;
    end else if (d_srcb == bus.M_dstE) begin
      d_valb = bus.M_valE;
    end else if (d_srcb == bus.W_dstM) begin
      d_valb = bus.W_valM;
    end else if (d_srcb == bus.W_dstE) begin
      d_valb = bus.W_valE;
    end else begin
      d_valb = rf_b;
    end
  end

  // E pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= E_BUBBLE;
    end else if (bus.E_bubble) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= '{
        err: d_q.err, icode: d_q.icode, ifun: d_q.ifun, valc: d_q.valc,
        vala: d_vala, valb: d_valb,
        dste: d_dste, dstm: d_dstm, srca: d_srca, srcb: d_srcb
      };
    end
  end

  // Register file write-back. The valM write comes second so it wins when
  // both ports target the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.W_dstE == 4'(i)) regs[i] <= bus.W_valE;
        if (bus.W_dstM == 4'(i)) regs[i] <= bus.W_valM;
      end
    end
  end

  assign bus.d_srcA  = d_srca;
  assign bus.d_srcB  = d_srcb;
  assign bus.E_err   = e_q.err;
  assign bus.E_icode = e_q.icode;
  assign bus.E_ifun  = e_q.ifun;
  assign bus.E_valC  = e_q.valc;
  assign bus.E_valA  = e_q.vala;
  assign bus.E_valB  = e_q.valb;
  assign bus.E_dstE  = e_q.dste;
  assign bus.E_dstM  = e_q.dstm;
  assign bus.E_srcA  = e_q.srca;
  assign bus.E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_y86_decode_stage.sv
// tb_y86_decode_stage
//   Directed-vector bench for y86_decode_stage. Each stimulus cycle pushes the
//   hand-computed E register contents expected after that edge; a monitor
//   pops one entry per edge and compares every E field.
module tb_y86_decode_stage;

  localparam logic [3:0] F = 4'hF;

  typedef struct {
    string       name;
    logic        err;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  y86_decode_stage_if bus ();

  y86_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [144:0] fb(input logic err, input logic [3:0] icode,
                                      input logic [3:0] ifun, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [63:0] valc,
                                      input logic [63:0] valp);
    return {err, icode, ifun, ra, rb, valc, valp};
  endfunction

  function automatic exp_t ex(input string name, input logic err,
                              input logic [3:0] icode, input logic [3:0] ifun,
                              input logic [63:0] valc, input logic [63:0] vala,
                              input logic [63:0] valb, input logic [3:0] dste,
                              input logic [3:0] dstm, input logic [3:0] srca,
                              input logic [3:0] srcb);
    exp_t e;
    e.name = name; e.err = err; e.icode = icode; e.ifun = ifun;
    e.valc = valc; e.vala = vala; e.valb = valb;
    e.dste = dste; e.dstm = dstm; e.srca = srca; e.srcb = srcb;
    return e;
  endfunction

  function automatic exp_t nopExp(input string name);
    return ex(name, 1'b0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, F);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic idleFwd();
    bus.e_dstE = F; bus.e_valE = '0;
    bus.M_dstM = F; bus.m_valM = '0;
    bus.M_dstE = F; bus.M_valE = '0;
    bus.W_dstM = F; bus.W_valM = '0;
    bus.W_dstE = F; bus.W_valE = '0;
  endtask

  // Called just after a falling edge: present the fetch bundle, record the
  // E contents expected after the next rising edge, then wait one cycle.
  task automatic applyStimulus(input logic [144:0] fetch, input exp_t e);
    bus.f_bundle = fetch;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Scoreboard monitor: one E register update per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.name, ".err"},   64'(bus.E_err),   64'(e.err));
        checkOutput({e.name, ".icode"}, 64'(bus.E_icode), 64'(e.icode));
        checkOutput({e.name, ".ifun"},  64'(bus.E_ifun),  64'(e.ifun));
        checkOutput({e.name, ".valC"},  bus.E_valC,       e.valc);
        checkOutput({e.name, ".valA"},  bus.E_valA,       e.vala);
        checkOutput({e.name, ".valB"},  bus.E_valB,       e.valb);
        checkOutput({e.name, ".dstE"},  64'(bus.E_dstE),  64'(e.dste));
        checkOutput({e.name, ".dstM"},  64'(bus.E_dstM),  64'(e.dstm));
        checkOutput({e.name, ".srcA"},  64'(bus.E_srcA),  64'(e.srca));
        checkOutput({e.name, ".srcB"},  64'(bus.E_srcB),  64'(e.srcb));
      end
    end
  end

  initial begin
    logic [144:0] nop_f;
    n_checks = 0;
    n_fail   = 0;
    nop_f    = fb(1'b0, 4'h1, 4'h0, F, F, 64'h0, 64'h0);

    rst = 1'b1;
    bus.f_bundle = nop_f;
    bus.D_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    idleFwd();
    repeat (2) @(negedge clk);
    checkOutput("rst.E_icode", 64'(bus.E_icode), 64'h1);
    checkOutput("rst.E_srcA",  64'(bus.E_srcA),  64'hF);
    rst = 1'b0;

    // Write-back of r3, then OPq r3,r3 reads it through the file.
    bus.W_dstE = 4'h3; bus.W_valE = 64'h55;
    applyStimulus(fb(1'b0, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h2), nopExp("a_nop"));
    idleFwd();
    applyStimulus(nop_f, ex("wb_opq", 1'b0, 4'h6, 4'h0, 64'h0, 64'h55, 64'h55, 4'h3, F, 4'h3, 4'h3));

    // Forwarding priority on srcA=2 (rrmovq r2 -> r6), D held for a second look.
    applyStimulus(fb(1'b0, 4'h2, 4'h0, 4'h2, 4'h6, 64'h0, 64'h2), nopExp("c_nop"));
    bus.e_dstE = 4'h2; bus.e_valE = 64'h11;
    bus.M_dstE = 4'h2; bus.M_valE = 64'h22;
    bus.W_dstE = 4'h2; bus.W_valE = 64'h33;
    bus.D_stall = 1'b1;
    applyStimulus(nop_f, ex("fwd_e", 1'b0, 4'h2, 4'h0, 64'h0, 64'h11, 64'h0, 4'h6, F, 4'h2, F));
    bus.D_stall = 1'b0;
    bus.e_dstE = F;
    applyStimulus(fb(1'b0, 4'h6, 4'h1, 4'h2, 4'h7, 64'h0, 64'h2),
                  ex("fwd_m", 1'b0, 4'h2, 4'h0, 64'h0, 64'h22, 64'h0, 4'h6, F, 4'h2, F));
    // r2 now holds 0x33 in the file; valB on r7 takes m_valM over M_valE.
    idleFwd();
    bus.M_dstM = 4'h7; bus.m_valM = 64'h77;
    bus.M_dstE = 4'h7; bus.M_valE = 64'h78;
    applyStimulus(nop_f, ex("fwd_mm", 1'b0, 4'h6, 4'h1, 64'h0, 64'h33, 64'h77, 4'h7, F, 4'h2, 4'h7));

    // Same-index write-back: valM wins.
    idleFwd();
    bus.W_dstE = 4'h5; bus.W_valE = 64'hA;
    bus.W_dstM = 4'h5; bus.W_valM = 64'hB;
    applyStimulus(fb(1'b0, 4'h6, 4'h0, 4'h5, 4'h5, 64'h0, 64'h2), nopExp("g_nop"));
    idleFwd();
    applyStimulus(nop_f, ex("wb_same", 1'b0, 4'h6, 4'h0, 64'h0, 64'hB, 64'hB, 4'h5, F, 4'h5, 4'h5));
    checkOutput("rf5", dut.regs[5], 64'hB);

    // Stall and bubble together: D holds irmovq while fetch changes.
    bus.W_dstE = 4'h4; bus.W_valE = 64'h1000;
    applyStimulus(fb(1'b0, 4'h3, 4'h0, F, 4'h1, 64'h1234, 64'hA), nopExp("i_nop"));
    idleFwd();
    bus.D_stall = 1'b1; bus.D_bubble = 1'b1;
    applyStimulus(fb(1'b0, 4'h8, 4'h0, F, F, 64'h100, 64'h40),
                  ex("stall1", 1'b0, 4'h3, 4'h0, 64'h1234, 64'h0, 64'h0, 4'h1, F, F, F));
    applyStimulus(fb(1'b0, 4'hA, 4'h0, 4'h2, F, 64'h0, 64'h2),
                  ex("stall2", 1'b0, 4'h3, 4'h0, 64'h1234, 64'h0, 64'h0, 4'h1, F, F, F));
    bus.D_stall = 1'b0;
    applyStimulus(fb(1'b0, 4'hB, 4'h0, 4'h1, F, 64'h0, 64'h2),
                  ex("stall3", 1'b0, 4'h3, 4'h0, 64'h1234, 64'h0, 64'h0, 4'h1, F, F, F));
    bus.D_bubble = 1'b0;
    applyStimulus(fb(1'b0, 4'h8, 4'h0, F, F, 64'h100, 64'h40), nopExp("bubble_rel"));

    // call then popq.
    applyStimulus(fb(1'b0, 4'hB, 4'h0, 4'h1, F, 64'h0, 64'h42),
                  ex("call", 1'b0, 4'h8, 4'h0, 64'h100, 64'h40, 64'h1000, 4'h4, F, F, 4'h4));
    applyStimulus(fb(1'b0, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h2),
                  ex("popq", 1'b0, 4'hB, 4'h0, 64'h0, 64'h1000, 64'h1000, 4'h4, 4'h1, 4'h4, 4'h4));

    // E bubble discards the OPq sitting in D.
    bus.E_bubble = 1'b1;
    applyStimulus(nop_f, nopExp("e_bubble"));
    bus.E_bubble = 1'b0;

    // err/halt passes through untouched.
    applyStimulus(fb(1'b1, 4'h0, 4'h0, F, F, 64'h0, 64'h55), nopExp("q_nop"));
    applyStimulus(nop_f, ex("err_halt", 1'b1, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, F, F, F, F));

    // Load OPq into E, then reset mid-cycle.
    applyStimulus(fb(1'b0, 4'h6, 4'h0, 4'h3, 4'h3, 64'h0, 64'h2), nopExp("s_nop"));
    applyStimulus(nop_f, ex("pre_rst", 1'b0, 4'h6, 4'h0, 64'h0, 64'h55, 64'h55, 4'h3, F, 4'h3, 4'h3));
    checkOutput("rf3_pre", dut.regs[3], 64'h55);

    #2 rst = 1'b1;
    #1;
    checkOutput("arst.E_icode", 64'(bus.E_icode), 64'h1);
    checkOutput("arst.E_dstE",  64'(bus.E_dstE),  64'hF);
    checkOutput("arst.E_dstM",  64'(bus.E_dstM),  64'hF);
    checkOutput("arst.E_srcA",  64'(bus.E_srcA),  64'hF);
    checkOutput("arst.E_srcB",  64'(bus.E_srcB),  64'hF);
    checkOutput("arst.E_valA",  bus.E_valA,       64'h0);
    checkOutput("arst.rf3",     dut.regs[3],      64'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(nop_f, nopExp("post_rst"));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    checkOutput("sb_drain", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_decode_stage.md
Name: y86_decode_stage

Overview:
- Pipeline stage directly downstream of fetch in the Y86-64 five-stage processor.
- Latches the 145-bit fetch bundle into the D pipeline register.
- Decodes register sources and destinations, reads the 15x64 register file, and forwards from E/M/W.
- Loads the E pipeline register consumed by execute; also owns the register file and performs write-back from the W stage.

Parameters:
- DATA_W, 64, datapath width of valC/valP/register values
- NREG, 15, architectural registers (%rax..%r14); index 4'hF is RNONE

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- f_bundle  in  145  fetch output: [144]=err, [143:140]=icode, [139:136]=ifun, [135:132]=rA, [131:128]=rB, [127:64]=valC, [63:0]=valP
- D_stall  in  1  hold D register
- D_bubble  in  1  load nop into D register
- E_bubble  in  1  load nop into E register
- e_dstE  in  4  execute destE; e_valE  in  64  ALU result
- M_dstM  in  4  memory-stage dstM; m_valM  in  64  memory read data
- M_dstE  in  4  memory-stage dstE; M_valE  in  64  memory-stage valE
- W_dstM  in  4  write-back dstM; W_valM  in  64
- W_dstE  in  4  write-back dstE; W_valE  in  64
- d_srcA, d_srcB  out  4  combinational sources, to hazard unit
- E_err  out  1  registered pipeline error flag
- E_icode, E_ifun  out  4 each
- E_valC, E_valA, E_valB  out  64 each
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each

Behaviour:
- Reset (async, immediate): D register and E register load bubble: icode=1 (nop), ifun=0, err=0, all vals 0, all reg fields 4'hF. All 15 registers cleared to 0.
- D register update per edge, priority order:
  - D_stall: hold current contents.
  - else D_bubble: load bubble.
  - else: load f_bundle.
  - If both asserted, stall wins.
- Decode uses D register fields (icode codes: 0 halt, 1 nop, 2 rrmovq/cmov, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq):
  - srcA = rA for {2,4,6,A}; 4 for {9,B}; else F.
  - srcB = rB for {4,5,6}; 4 for {8,9,A,B}; else F.
  - dstE = rB for {2,3,6}; 4 for {8,9,A,B}; else F.
  - dstM = rA for {5,B}; else F.
- valA:
  - icode in {7,8}: valP.
  - else forward, first match with srcA!=F: e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE; else regfile[srcA].
  - srcA=F gives 0.
- valB: same forwarding chain on srcB, without the valP case.
- E register per edge:
  - E_bubble: bubble.
  - else: decoded values plus D icode/ifun/valC/err.
  - Latency: fetch bundle appears at E outputs two edges after presentation, absent stalls.
- Register file:
  - Written on rising edge: W_dstE<-W_valE, then W_dstM<-W_valM; when the indices are equal, W_valM wins.
  - Index F writes are ignored.
  - Reads are combinational; the W forwarding path covers same-cycle write/read.
- Halt/err: no special action here; passed through to E unchanged.

Test Plan:
- Reset mid-run with E holding OPq -> E_icode=1, all E_dst/src=F, regfile[3]=0 immediately, before the next edge.
- Write-back W_dstE=3, W_valE=64'h55, then decode OPq rA=3 rB=3 with no forwarding -> E_valA=E_valB=64'h55, E_dstE=3.
- Forwarding priority: srcA=2 with e_dstE=2 (valE=0x11), M_dstE=2 (0x22), W_dstE=2 (0x33) -> E_valA=0x11; drop e_dstE -> 0x22.
- Same-index write-back W_dstE=W_dstM=5 with valE=0xA, valM=0xB -> regfile[5]=0xB.
- D_stall and D_bubble both high for 2 edges while fetch changes -> D contents unchanged; release D_stall with D_bubble high -> E receives nop.
- call with valP=0x40 -> E_valA=0x40, E_srcB=4, E_dstE=4, E_dstM=F; popq rA=1 -> E_srcA=4, E_dstM=1.
